wordle_score_ctrl: RTL
======================

// Module: wordle_score_ctrl
// PURPOSE
//  Sequences scoring of one 5-letter guess against the secret word and writes
//  per-tile colour codes into the board colour store (6 rows x 5 cols x 3b RGB).
//  Sits between wordle_sm (issues Start when a guess is submitted) and the VGA
//  colour array. Duplicate letters follow real Wordle rules: greens first, then
//  yellows consume unused secret letters left to right.
// PARAMETERS
//  LETTERS  5  letters per word; fixed at 5, other values unsupported
//  CHAR_W   8  bits per letter (ASCII)
//  ROWS     6  board rows; a row_idx >= ROWS is an error
//  COLOR_W  3  colour code width {R,G,B}
// PORTS
//  Clk        in   1   system clock; all logic on posedge
//  reset      in   1   synchronous, active-high
//  Start      in   1   request scoring; sampled only in IDLE
//  guess      in   40  guessed word; letter 0 = [39:32] .. letter 4 = [7:0]
//  secret     in   40  secret word, same packing
//  row_idx    in   3   target board row 0..ROWS-1
//  busy       out  1   high from acceptance through DONE
//  wr_en      out  1   colour-store write strobe
//  wr_row     out  3   write row (= latched row_idx)
//  wr_col     out  3   write column 0..4
//  wr_color   out  3   GREEN 3'b010, YELLOW 3'b110, MISS 3'b111
//  done       out  1   one-cycle pulse, end of operation
//  win        out  1   valid with done: all five tiles GREEN
//  err        out  1   valid with done: row_idx out of range, nothing written
// BEHAVIOUR
//  - Reset: state IDLE; busy, wr_en, done, win, err = 0; wr_row, wr_col,
//    wr_color = 0; internal used/green masks cleared. Reset mid-operation aborts
//    immediately; no further writes are issued.
//  - All outputs registered. Cycle n = interval after the n-th posedge
//    following the edge (edge 0) that samples Start=1 in IDLE.
//  - Edge 0 latches guess, secret, row_idx; clears used[4:0], green[4:0].
//    row_idx >= ROWS -> DONE with err=1 (done, busy, err high cycle 0 only).
//  - GREEN (edges 1-5, i=0..4): guess[i]==secret[i] -> green[i]=1, used[i]=1.
//  - YELLOW (edges 6-10, i=0..4): if !green[i], lowest j with !used[j] and
//    secret[j]==guess[i] -> yellow[i]=1, used[j]=1; no match -> MISS.
//  - WRITE: wr_en=1 cycles 10-14, wr_col = 0..4 in order, wr_color per tile.
//  - DONE: cycle 15 done=1, win=&green, err=0; busy=1. Edge 16 -> IDLE,
//    busy=0, done=0; Start can be accepted again at edge 16.
//  - Start while busy ignored (not queued). guess/secret/row_idx changes while
//    busy have no effect. win/err hold last value until next done.
//  - Letters compared as raw 8-bit values; no case folding.
// STRUCTURE
//  - wordle_pkg: colour constants (GREEN/YELLOW/MISS), state encoding
//    (IDLE, GREEN, YELLOW, WRITE, DONE), LETTERS/CHAR_W defaults.
//  - One sub-module: wordle_letter_match - combinational; inputs letter,
//    secret, used mask; outputs hit and one-hot lowest unused matching position.
//  - 3-bit letter index counter shared by GREEN/YELLOW/WRITE.
// TESTING
//  1. secret "CRANE", guess "CRANE", row 0 -> writes 010x5 cols 0-4 in
//     cycles 10-14; done cycle 15, win=1, err=0.
//  2. secret "APPLE", guess "PAPER", row 2 -> colours 110,110,010,110,111;
//     win=0.
//  3. secret "ABBEY", guess "BOBBY", row 5 -> 110,111,010,111,010 (third B
//     MISS: duplicate consumed).
//  4. row_idx=6 -> no wr_en, done+err in cycle 0, busy low at cycle 1; Start
//     re-pulsed during cycles 1-14 of a valid run -> ignored, exactly 5 writes.
//  5. reset asserted in cycle 12 -> next cycle all outputs 0, no writes to
//     cols 3-4, no done; new Start after reset scores correctly.

Source files
------------

// File: rtl/wordle_pkg.sv
// Shared types and constants for Wordle guess scoring: tile colours,
// scoring FSM states and default word geometry.
package wordle_pkg;

    localparam int DEF_LETTERS = 5;
    localparam int DEF_CHAR_W  = 8;
    localparam int DEF_ROWS    = 6;
    localparam int DEF_COLOR_W = 3;

    localparam logic [DEF_COLOR_W-1:0] COLOR_GREEN  = 3'b010;
    localparam logic [DEF_COLOR_W-1:0] COLOR_YELLOW = 3'b110;
    localparam logic [DEF_COLOR_W-1:0] COLOR_MISS   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_WRITE,
        ST_DONE
    } state_e;

    function automatic logic [DEF_COLOR_W-1:0] tile_color(input logic is_green, input logic is_yellow);
        if (is_green) begin
            return COLOR_GREEN;
        end else if (is_yellow) begin
            return COLOR_YELLOW;
        end
        return COLOR_MISS;
    endfunction

endpackage

// File: rtl/wordle_letter_match.sv
// Finds the lowest secret position holding a given letter that has not yet
// been consumed by an earlier green or yellow tile.
module wordle_letter_match
#(
    parameter int LETTERS = 5,
    parameter int CHAR_W  = 8
)
(
    input  logic [CHAR_W-1:0]         letter,
    input  logic [LETTERS*CHAR_W-1:0] secret,
    input  logic [LETTERS-1:0]        used,
    output logic                      hit,
    output logic [LETTERS-1:0]        pos
);

    always_comb begin
        logic found;
        found = 1'b0;
        pos   = '0;
        for (int unsigned j = 0; j < LETTERS; j++) begin
            if (!found && !used[j] && secret[(LETTERS-1-j)*CHAR_W +: CHAR_W] == letter) begin
                found  = 1'b1;
                pos[j] = 1'b1;
            end
        end
        hit = found;
    end

endmodule

// File: rtl/wordle_score_ctrl.sv
// Scores one guess against the secret (greens pass, then yellows pass) and
// streams the five tile colours into the board colour store.
module wordle_score_ctrl
    import wordle_pkg::*;
#(
    parameter int LETTERS = DEF_LETTERS,
    parameter int CHAR_W  = DEF_CHAR_W,
    parameter int ROWS    = DEF_ROWS,
    parameter int COLOR_W = DEF_COLOR_W
)
(
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      Start,
    input  logic [LETTERS*CHAR_W-1:0] guess,
    input  logic [LETTERS*CHAR_W-1:0] secret,
    input  logic [2:0]                row_idx,
    output logic                      busy,
    output logic                      wr_en,
    output logic [2:0]                wr_row,
    output logic [2:0]                wr_col,
    output logic [COLOR_W-1:0]        wr_color,
    output logic                      done,
    output logic                      win,
    output logic                      err
);

    state_e                    state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic [LETTERS*CHAR_W-1:0] guess_q, guess_d;
    logic [LETTERS*CHAR_W-1:0] secret_q, secret_d;
    logic [LETTERS-1:0]        green_q, green_d;
    logic [LETTERS-1:0]        yellow_q, yellow_d;
    logic [LETTERS-1:0]        used_q, used_d;
    logic                      busy_q, busy_d;
    logic                      wr_en_q, wr_en_d;
    logic [2:0]                wr_row_q, wr_row_d;
    logic [2:0]                wr_col_q, wr_col_d;
    logic [COLOR_W-1:0]        wr_color_q, wr_color_d;
    logic                      done_q, done_d;
    logic                      win_q, win_d;
    logic                      err_q, err_d;

    logic [CHAR_W-1:0]         g_let [LETTERS];
    logic [CHAR_W-1:0]         s_let [LETTERS];
    logic                      match_hit;
    logic [LETTERS-1:0]        match_pos;

    always_comb begin
        for (int unsigned i = 0; i < LETTERS; i++) begin
            g_let[i] = guess_q[(LETTERS-1-i)*CHAR_W +: CHAR_W];
            s_let[i] = secret_q[(LETTERS-1-i)*CHAR_W +: CHAR_W];
        end
    end

    wordle_letter_match #(
        .LETTERS (LETTERS),
        .CHAR_W  (CHAR_W)
    ) u_match (
        .letter (g_let[idx_q]),
        .secret (secret_q),
        .used   (used_q),
        .hit    (match_hit),
        .pos    (match_pos)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        guess_d    = guess_q;
        secret_d   = secret_q;
        green_d    = green_q;
        yellow_d   = yellow_q;
        used_d     = used_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_color_d = wr_color_q;
        done_d     = 1'b0;
        win_d      = win_q;
        err_d      = err_q;

        unique case (state_q)
            ST_GREEN: begin
                if (g_let[idx_q] == s_let[idx_q]) begin
                    green_d[idx_q] = 1'b1;
                    used_d[idx_q]  = 1'b1;
                end
                if (idx_q == 3'(LETTERS-1)) begin
                    state_d = ST_YELLOW;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_YELLOW: begin
                if (!green_q[idx_q] && match_hit) begin
                    yellow_d[idx_q] = 1'b1;
                    used_d          = used_q | match_pos;
                end
                // Tile 0 is final by now, so its write overlaps the last yellow step.
                if (idx_q == 3'(LETTERS-1)) begin
                    state_d    = ST_WRITE;
                    idx_d      = 3'd1;
                    wr_en_d    = 1'b1;
                    wr_col_d   = '0;
                    wr_color_d = tile_color(green_q[0], yellow_q[0]);
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_WRITE: begin
                if (idx_q == 3'(LETTERS)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    win_d   = &green_q;
                    err_d   = 1'b0;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_col_d   = idx_q;
                    wr_color_d = tile_color(green_q[idx_q], yellow_q[idx_q]);
                    idx_d      = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
            end
        endcase

        // A new request is taken in IDLE and also on the DONE -> IDLE edge.
        if ((state_q == ST_IDLE || state_q == ST_DONE) && Start) begin
            guess_d  = guess;
            secret_d = secret;
            wr_row_d = row_idx;
            green_d  = '0;
            yellow_d = '0;
            used_d   = '0;
            idx_d    = '0;
            busy_d   = 1'b1;
            if (row_idx >= 3'(ROWS)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                win_d   = 1'b0;
            end else begin
                state_d = ST_GREEN;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            guess_q    <= '0;
            secret_q   <= '0;
            green_q    <= '0;
            yellow_q   <= '0;
            used_q     <= '0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_color_q <= '0;
            done_q     <= 1'b0;
            win_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            guess_q    <= guess_d;
            secret_q   <= secret_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            used_q     <= used_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_color_q <= wr_color_d;
            done_q     <= done_d;
            win_q      <= win_d;
            err_q      <= err_d;
        end
    end

    assign busy     = busy_q;
    assign wr_en    = wr_en_q;
    assign wr_row   = wr_row_q;
    assign wr_col   = wr_col_q;
    assign wr_color = wr_color_q;
    assign done     = done_q;
    assign win      = win_q;
    assign err      = err_q;

endmodule
